// File: rtl/bsswap_axis.sv
// AXI-Stream byte-lane permuter with a per-packet latched lane order, a
// registered output stage and a skid entry so s_tready never depends on m_tready.

module bsswap_lane (
  input  logic [1:0]      mode,
  input  logic [3:0][7:0] cand,
  input  logic [3:0]      cand_keep,
  output logic [7:0]      lane_byte,
  output logic            lane_keep
);
  // cand/cand_keep are pre-wired per lane: 0 identity, 1 reverse, 2 swap8, 3 swap16
  assign lane_byte = cand[mode];
  assign lane_keep = cand_keep[mode];
endmodule

module bsswap_axis #(
  parameter int BYTES    = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cfg_mode,
  input  logic [BYTES*8-1:0]    s_tdata,
  input  logic [BYTES-1:0]      s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [BYTES*8-1:0]    m_tdata,
  output logic [BYTES-1:0]      m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [CNT_BITS-1:0]   pkt_cnt
);

  if (!(BYTES == 2 || BYTES == 4 || BYTES == 8 || BYTES == 16)) begin : g_bad_bytes
    $error("bsswap_axis: BYTES must be 2, 4, 8 or 16");
  end

  typedef struct packed {
    logic [BYTES-1:0][7:0] data;
    logic [BYTES-1:0]      keep;
    logic                  last;
  } beat_t;

  logic [BYTES-1:0][7:0] in_b;
  logic [BYTES-1:0][7:0] perm_data;
  logic [BYTES-1:0]      perm_keep;
  beat_t                 in_beat, out_q, skid_q;
  logic                  out_vld, skid_vld, run, sop;
  logic [1:0]            mode_q, mode;
  logic                  s_acc, m_acc;

  assign in_b  = s_tdata;
  // First beat of a packet uses the live cfg_mode; the rest use the latched copy
  assign mode  = sop ? cfg_mode : mode_q;
  assign s_acc = s_tvalid & s_tready;
  assign m_acc = m_tvalid & m_tready;

  for (genvar k = 0; k < BYTES; k++) begin : g_lane
    localparam int REV  = BYTES - 1 - k;
    localparam int SW8  = k ^ 1;
    // A 2-byte bus has no second 16-bit half, so swap16 degenerates to identity
    localparam int SW16 = (BYTES > 2) ? (k ^ 2) : k;
    bsswap_lane u_lane (
      .mode      (mode),
      .cand      ({in_b[SW16], in_b[SW8], in_b[REV], in_b[k]}),
      .cand_keep ({s_tkeep[SW16], s_tkeep[SW8], s_tkeep[REV], s_tkeep[k]}),
      .lane_byte (perm_data[k]),
      .lane_keep (perm_keep[k])
    );
  end

  assign in_beat = {perm_data, perm_keep, s_tlast};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run      <= 1'b0;
      sop      <= 1'b1;
      mode_q   <= 2'd0;
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
      pkt_cnt  <= '0;
    end else begin
      run <= 1'b1;
      if (s_acc) begin
        sop <= s_tlast;
        if (sop) mode_q <= cfg_mode;
      end
      if (!out_vld || m_acc) begin
        if (skid_vld) begin
          out_q    <= skid_q;
          out_vld  <= 1'b1;
          skid_vld <= s_acc;
          if (s_acc) skid_q <= in_beat;
        end else if (s_acc) begin
          out_q   <= in_beat;
          out_vld <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (s_acc) begin
        skid_q   <= in_beat;
        skid_vld <= 1'b1;
      end
      if (m_acc && out_q.last) pkt_cnt <= pkt_cnt + CNT_BITS'(1);
    end
  end

  assign s_tready = run & ~skid_vld;
  assign m_tvalid = out_vld;
  assign m_tdata  = out_q.data;
  assign m_tkeep  = out_q.keep;
  assign m_tlast  = out_q.last;

endmodule

// File: tb/tb_bsswap_axis.sv
// Directed bench for bsswap_axis: a BYTES=4 instance for most scenarios and a
// BYTES=8 / CNT_BITS=4 instance for wide-lane modes and counter wrap.

module tb_bsswap_axis;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;

  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast, m_tvalid, m_tready = 1'b1;
  logic [15:0] pkt_cnt;

  logic [63:0] e_sdata = '0;
  logic [7:0]  e_skeep = '0;
  logic        e_slast = 1'b0, e_svalid = 1'b0, e_sready;
  logic [63:0] e_mdata;
  logic [7:0]  e_mkeep;
  logic        e_mlast, e_mvalid, e_mready = 1'b1;
  logic [3:0]  e_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsswap_axis #(.BYTES(4), .CNT_BITS(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .pkt_cnt(pkt_cnt));

  bsswap_axis #(.BYTES(8), .CNT_BITS(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
    .s_tdata(e_sdata), .s_tkeep(e_skeep), .s_tlast(e_slast), .s_tvalid(e_svalid),
    .s_tready(e_sready), .m_tdata(e_mdata), .m_tkeep(e_mkeep), .m_tlast(e_mlast),
    .m_tvalid(e_mvalid), .m_tready(e_mready), .pkt_cnt(e_cnt));

  function automatic logic [31:0] rev4(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Present one beat on dut4 and wait (bounded) for its accepting edge; returns #1 after it
  task automatic push4(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic acc;
    acc = 1'b0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = s_tready;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL push4_accept: s_tready=%b required 1", s_tready); end
  endtask

  task automatic push8(input logic [63:0] d, input logic [7:0] k, input logic l);
    logic acc;
    acc = 1'b0;
    e_sdata = d; e_skeep = k; e_slast = l; e_svalid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = e_sready;
      @(posedge clk); #1;
    end
    e_svalid = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL push8_accept: s_tready=%b required 1", e_sready); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b want 0", m_tvalid); end
    if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b want 0", s_tready); end
    if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt); end
    if (m_tdata !== 32'd0 || m_tkeep !== 4'd0 || m_tlast !== 1'b0) begin
      errors++; $display("FAIL rst_m_data: got %h/%h/%b want 0/0/0", m_tdata, m_tkeep, m_tlast);
    end
    if (e_mvalid !== 1'b0 || e_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_dut8: got vld=%b cnt=%0d want 0/0", e_mvalid, e_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_tready !== 1'b1 || e_sready !== 1'b1) begin
      errors++; $display("FAIL rst_release_ready: got %b/%b want 1/1", s_tready, e_sready);
    end
  endtask

  task automatic test_modes4;
    logic [1:0]  md [4]  = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0]  ki [4]  = '{4'hE, 4'h1, 4'h1, 4'h5};
    logic [31:0] ed [4]  = '{32'h44332211, 32'h22114433, 32'h33441122, 32'h11223344};
    logic [3:0]  ek [4]  = '{4'h7, 4'h2, 4'h4, 4'h5};
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_mode = md[i];
      push4(32'h11223344, ki[i], 1'b1);
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== ed[i] || m_tkeep !== ek[i] || m_tlast !== 1'b1) begin
        errors++;
        $display("FAIL mode4_%0d: got v=%b d=%h k=%h l=%b want 1/%h/%h/1",
                 md[i], m_tvalid, m_tdata, m_tkeep, m_tlast, ed[i], ek[i]);
      end
      if (i == 0) begin
        checks++;
        if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL cnt_before: got %0d want 0", pkt_cnt); end
        @(posedge clk); #1;
        checks++;
        if (pkt_cnt !== 16'd1 || m_tvalid !== 1'b0) begin
          errors++; $display("FAIL cnt_after: got cnt=%0d vld=%b want 1/0", pkt_cnt, m_tvalid);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_modes8;
    logic [1:0]  md [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
    logic [63:0] ed [4] = '{64'h1100332255447766, 64'h2233001166774455,
                            64'h7766554433221100, 64'h0011223344556677};
    logic [7:0]  ek [4] = '{8'h02, 8'h04, 8'h80, 8'h01};
    e_mready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_mode = md[i];
      push8(64'h0011223344556677, 8'h01, 1'b1);
      checks++;
      if (e_mvalid !== 1'b1 || e_mdata !== ed[i] || e_mkeep !== ek[i] || e_mlast !== 1'b1) begin
        errors++;
        $display("FAIL mode8_%0d: got v=%b d=%h k=%h l=%b want 1/%h/%h/1",
                 md[i], e_mvalid, e_mdata, e_mkeep, e_mlast, ed[i], ek[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mode_latch;
    logic [31:0] din [4] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
    logic [31:0] dex [4] = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0, 32'hD3D2D1D0};
    m_tready = 1'b1;
    cfg_mode = 2'd1;
    for (int i = 0; i < 4; i++) begin
      push4(din[i], 4'hF, i == 3);
      cfg_mode = 2'd0;
      checks++;
      if (m_tdata !== dex[i] || m_tlast !== (i == 3) || s_tready !== 1'b1) begin
        errors++;
        $display("FAIL latch_beat%0d: got d=%h l=%b rdy=%b want %h/%b/1",
                 i, m_tdata, m_tlast, s_tready, dex[i], i == 3);
      end
    end
    push4(32'h01020304, 4'h3, 1'b1);
    checks++;
    if (m_tdata !== 32'h01020304 || m_tkeep !== 4'h3) begin
      errors++; $display("FAIL latch_next_pkt: got %h/%h want 01020304/3", m_tdata, m_tkeep);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall;
    m_tready = 1'b0;
    cfg_mode = 2'd0;
    push4(32'h12345678, 4'hF, 1'b0);
    push4(32'h9ABCDEF0, 4'hF, 1'b1);
    checks++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b1) begin
      errors++; $display("FAIL stall_full: got rdy=%b vld=%b want 0/1", s_tready, m_tvalid);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_tdata !== 32'h12345678 || m_tkeep !== 4'hF || m_tlast !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got %h/%h/%b want 12345678/f/0", i, m_tdata, m_tkeep, m_tlast);
      end
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (m_tdata !== 32'h9ABCDEF0 || m_tlast !== 1'b1 || s_tready !== 1'b1) begin
      errors++; $display("FAIL stall_drain: got %h/%b rdy=%b want 9abcdef0/1/1", m_tdata, m_tlast, s_tready);
    end
    @(posedge clk); #1;
    checks++;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b want 0", m_tvalid); end
  endtask

  task automatic test_random;
    logic [31:0] exp_q [$];
    logic [31:0] cur, want;
    logic [36:0] hold;
    logic        stalled, in_acc, out_acc, prev_rdy, prev_mrdy;
    int          sent, rcv;
    sent = 0; rcv = 0; stalled = 0; prev_rdy = 1; prev_mrdy = 0;
    cur = $urandom;
    cfg_mode = 2'd1;
    for (int cyc = 0; cyc < 600 && rcv < 40; cyc++) begin
      m_tready = 1'($urandom_range(0, 1));
      s_tvalid = (sent < 40);
      s_tdata = cur; s_tkeep = 4'hF; s_tlast = (sent == 39);
      if (!prev_rdy && prev_mrdy) begin
        checks++;
        if (s_tready !== 1'b1) begin errors++; $display("FAIL rand_ready_stuck: got 0 want 1 at cyc %0d", cyc); end
      end
      in_acc = s_tvalid & s_tready;
      out_acc = m_tvalid & m_tready;
      if (out_acc) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        checks++;
        if (m_tdata !== want) begin errors++; $display("FAIL rand_data%0d: got %h want %h", rcv, m_tdata, want); end
        rcv++;
      end
      stalled = m_tvalid & ~m_tready;
      hold = {m_tdata, m_tkeep, m_tlast};
      if (in_acc) begin
        exp_q.push_back(rev4(cur));
        sent++;
        cur = $urandom;
      end
      prev_rdy = s_tready; prev_mrdy = m_tready;
      @(posedge clk); #1;
      if (sent > 0) cfg_mode = 2'($urandom_range(0, 3));
      if (stalled) begin
        checks++;
        if ({m_tdata, m_tkeep, m_tlast} !== hold) begin
          errors++; $display("FAIL rand_stall_hold: got %h want %h", {m_tdata, m_tkeep, m_tlast}, hold);
        end
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    checks++;
    if (rcv != 40) begin errors++; $display("FAIL rand_count: got %0d beats want 40", rcv); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    m_tready = 1'b0;
    cfg_mode = 2'd1;
    push4(32'hAABBCCDD, 4'hF, 1'b0);
    push4(32'h11112222, 4'hF, 1'b0);
    checks++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b1) begin
      errors++; $display("FAIL mid_full: got rdy=%b vld=%b want 0/1", s_tready, m_tvalid);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m_tvalid !== 1'b0 || pkt_cnt !== 16'd0 || s_tready !== 1'b0 || m_tdata !== 32'd0) begin
      errors++; $display("FAIL mid_rst: got vld=%b cnt=%0d rdy=%b d=%h want 0/0/0/0", m_tvalid, pkt_cnt, s_tready, m_tdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL mid_release: got rdy=%b vld=%b want 1/0", s_tready, m_tvalid);
    end
    m_tready = 1'b1;
    cfg_mode = 2'd0;
    push4(32'h01234567, 4'h3, 1'b1);
    checks++;
    if (m_tdata !== 32'h01234567 || m_tkeep !== 4'h3 || m_tlast !== 1'b1) begin
      errors++; $display("FAIL mid_new_pkt: got %h/%h/%b want 01234567/3/1", m_tdata, m_tkeep, m_tlast);
    end
    @(posedge clk); #1;
    checks++;
    if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL mid_cnt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_wrap;
    e_mready = 1'b1;
    cfg_mode = 2'd0;
    for (int i = 1; i <= 17; i++) begin
      push8(64'(i), 8'hFF, 1'b1);
      if (i == 16) begin
        checks++;
        if (e_cnt !== 4'd15) begin errors++; $display("FAIL wrap_15: got %0d want 15", e_cnt); end
      end
      if (i == 17) begin
        checks++;
        if (e_cnt !== 4'd0) begin errors++; $display("FAIL wrap_0: got %0d want 0", e_cnt); end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (e_cnt !== 4'd1) begin errors++; $display("FAIL wrap_1: got %0d want 1", e_cnt); end
  endtask

  initial begin
    test_reset;
    test_modes4;
    test_modes8;
    test_mode_latch;
    test_stall;
    test_random;
    test_reset_mid;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
